kernel_job_arbiter: RTL and testbench
=====================================

KERNEL_JOB_ARBITER -- requirements
Module: kernel_job_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, lane width in bits.
REQ-002 SHALL have parameter LANES, default 4, tensor elements per job.
REQ-003 SHALL have parameter KERN_LAT, default 1, kernel cycles from issue to result valid; legal range 1..15.
REQ-004 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  input  2  per-requester job valid.
REQ-007 SHALL have port req_data  input  2*LANES*DATA_W  requester r tensor at bits [r*LANES*DATA_W +: LANES*DATA_W].
REQ-008 SHALL have port req_ready  output  2  per-requester job accept.
REQ-009 SHALL have port kern_in  output  LANES*DATA_W  tensor driven to shared kernel.
REQ-010 SHALL have port kern_issue  output  1  one-cycle job-start pulse to kernel.
REQ-011 SHALL have port kern_out  input  LANES*DATA_W  kernel result tensor.
REQ-012 SHALL have port rsp_valid  output  2  per-requester result valid.
REQ-013 SHALL have port rsp_data  output  LANES*DATA_W  result tensor.
REQ-014 SHALL have port rsp_ready  input  2  per-requester result accept.
REQ-015 SHALL have port grant_id  output  1  requester owning current job.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-017 SHALL have port job_count  output  16  completed-job count.

Function
REQ-018 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; one job in flight max.
REQ-019 IDLE: SHALL compute grant combinationally: single valid requester wins; both valid -> requester != last_grant wins.
REQ-020 SHALL assert req_ready[r] only in IDLE and only for the granted r; other bit 0; req_ready 0 in all other states.
REQ-021 On req_valid[r] & req_ready[r]: SHALL capture req_data slice r into kern_in, set grant_id=r, enter ISSUE next cycle.
REQ-022 ISSUE (cycle T): SHALL drive kern_issue=1 for exactly that cycle, load latency counter with KERN_LAT, enter WAIT.
REQ-023 WAIT: counter SHALL decrement each cycle; kern_out SHALL be sampled into rsp_data at the end of cycle T+KERN_LAT; state RESP from cycle T+KERN_LAT+1.
REQ-024 kern_in SHALL hold stable from capture until the next accepted job.
REQ-025 RESP: SHALL assert rsp_valid[grant_id]=1, other bit 0; rsp_data and rsp_valid held stable until rsp_ready[grant_id]=1.
REQ-026 rsp_ready on the non-owning bit SHALL be ignored.
REQ-027 On response handshake: SHALL set last_grant=grant_id, increment job_count, return to IDLE next cycle.
REQ-028 job_count SHALL wrap 0xFFFF -> 0x0000 without flag.
REQ-029 req_valid deasserted before accept SHALL leave state unchanged; no job issued.
REQ-030 New req_valid arriving while busy SHALL stall (req_ready=0) until IDLE; no request dropped.
REQ-031 Minimum job period SHALL be KERN_LAT+3 cycles with rsp_ready held high.

Reset
REQ-032 On reset: state IDLE; req_ready, rsp_valid, kern_issue, busy = 0; kern_in, rsp_data, job_count, counter, grant_id = 0; last_grant = 1 (requester 0 wins first contention).
REQ-033 Reset mid-job SHALL discard the job: no kern_issue, no rsp_valid, job_count unchanged from 0 after release.
REQ-034 After reset deassertion, first accept SHALL be possible in the first clock cycle.

Verification
REQ-035 Single job: req 0 valid with lanes {1,2,3,4}, kernel model returns {11,9,9,11}, KERN_LAT=1 -> kern_issue one pulse 1 cycle after accept, rsp_valid[0] 3 cycles after accept, rsp_data {11,9,9,11}, job_count=1.
REQ-036 Contention: both req_valid held high for 4 jobs -> grant order 0,1,0,1; rsp_valid bit matches owner each time.
REQ-037 Backpressure: rsp_ready[0] low for 5 cycles in RESP -> rsp_valid[0] and rsp_data stable for 5 cycles, req_ready both 0, no new kern_issue.
REQ-038 Wrong-owner ready: job of req 1, rsp_ready=2'b01 -> no handshake; rsp_ready=2'b10 -> completes.
REQ-039 Reset in WAIT: assert reset during WAIT -> all outputs 0 immediately, no rsp_valid after release, next contention grants req 0.
REQ-040 Wrap: preload via 65536 jobs (or force) job_count=0xFFFF, complete one job -> job_count=0x0000.

Source files
------------

// File: rtl/kernel_job_arbiter_if.sv
// kernel_job_arbiter_if: requester, kernel and response signals of kernel_job_arbiter
interface kernel_job_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int LANES = 4
);
    logic [1:0] req_valid;
    logic [2*LANES*DATA_W-1:0] req_data;
    logic [1:0] req_ready;
    logic [LANES*DATA_W-1:0] kern_in;
    logic kern_issue;
    logic [LANES*DATA_W-1:0] kern_out;
    logic [1:0] rsp_valid;
    logic [LANES*DATA_W-1:0] rsp_data;
    logic [1:0] rsp_ready;
    logic grant_id;
    logic busy;
    logic [15:0] job_count;
    modport slave (
        input req_valid, req_data, kern_out, rsp_ready,
        output req_ready, kern_in, kern_issue, rsp_valid, rsp_data, grant_id, busy, job_count
    );
    modport master (
        output req_valid, req_data, kern_out, rsp_ready,
        input req_ready, kern_in, kern_issue, rsp_valid, rsp_data, grant_id, busy, job_count
    );
endinterface

// File: rtl/kernel_job_arbiter.sv
// kernel_job_arbiter: two-requester round-robin arbiter sharing one fixed-latency tensor kernel,
// one job in flight, response held until the owning requester accepts it.
module kernel_job_arbiter #(
    parameter int DATA_W = 32,
    parameter int LANES = 4,
    parameter int KERN_LAT = 1
) (
    input logic clk,
    input logic reset,
    kernel_job_arbiter_if.slave bus
);
    localparam int TW = LANES * DATA_W;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nxt;
    logic [3:0] cnt;
    logic gid, last_grant, gnt, accept, sample, rsp_hs;
    logic [1:0] req_ready, rsp_valid;
    logic [TW-1:0] kin, rdata;
    logic [15:0] job_cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end
    // Contention goes to whoever was not served last; a lone requester always wins.
    always_comb begin
        gnt = (&bus.req_valid) ? ~last_grant : bus.req_valid[1];
        accept = state == IDLE && (|bus.req_valid) && !reset;
        sample = state == WAIT && cnt == 4'd1;
        rsp_hs = state == RESP && bus.rsp_ready[gid];
        req_ready = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
        rsp_valid = state == RESP ? (gid ? 2'b10 : 2'b01) : 2'b00;
        state_nxt = state == IDLE  ? (accept ? ISSUE : IDLE) :
                    state == ISSUE ? WAIT :
                    state == WAIT  ? (sample ? RESP : WAIT) :
                                     (rsp_hs ? IDLE : RESP);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kin <= '0;
            rdata <= '0;
            gid <= 1'b0;
            last_grant <= 1'b1;
            cnt <= '0;
            job_cnt <= '0;
        end else begin
            if (accept) begin
                kin <= gnt ? bus.req_data[2*TW-1:TW] : bus.req_data[TW-1:0];
                gid <= gnt;
            end
            if (state == ISSUE) cnt <= 4'(KERN_LAT);
            else if (state == WAIT) cnt <= cnt - 4'd1;
            if (sample) rdata <= bus.kern_out;
            if (rsp_hs) begin
                last_grant <= gid;
                job_cnt <= job_cnt + 16'd1;
            end
        end
    end
    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.kern_in = kin;
    assign bus.kern_issue = state == ISSUE;
    assign bus.rsp_data = rdata;
    assign bus.grant_id = gid;
    assign bus.busy = state != IDLE;
    assign bus.job_count = job_cnt;
endmodule

// File: tb/tb_kernel_job_arbiter.sv
// tb_kernel_job_arbiter: directed checks of arbitration, latency, backpressure, reset and count wrap
module tb_kernel_job_arbiter;
    localparam int DW = 32;
    localparam int LN = 4;
    localparam int TW = DW * LN;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    kernel_job_arbiter_if #(.DATA_W(DW), .LANES(LN)) bus ();
    kernel_job_arbiter #(.DATA_W(DW), .LANES(LN), .KERN_LAT(1)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    // Kernel stand-in: each lane computes x*x - 5x + 15
    always_comb begin
        for (int i = 0; i < LN; i++) begin
            bus.kern_out[i*DW +: DW] = bus.kern_in[i*DW +: DW] * bus.kern_in[i*DW +: DW]
                                       - 32'd5 * bus.kern_in[i*DW +: DW] + 32'd15;
        end
    end
    function automatic logic [TW-1:0] pack(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction
    task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask
    logic [TW-1:0] r0_in, r1_in, r0_out, r1_out;
    initial begin
        r0_in = pack(1, 2, 3, 4);
        r1_in = pack(5, 6, 7, 8);
        r0_out = pack(11, 9, 9, 11);
        r1_out = pack(15, 21, 29, 39);
        bus.req_valid = 2'b00;
        bus.req_data = {r1_in, r0_in};
        bus.rsp_ready = 2'b00;
        step(2);
        bus.req_valid = 2'b11;
        #1;
        check("rst_req_ready", TW'(bus.req_ready), 0);
        check("rst_busy", TW'(bus.busy), 0);
        check("rst_issue", TW'(bus.kern_issue), 0);
        check("rst_rsp_valid", TW'(bus.rsp_valid), 0);
        check("rst_job_count", TW'(bus.job_count), 0);
        check("rst_kern_in", bus.kern_in, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_grant", TW'(bus.grant_id), 0);
        // single job right after reset release
        step(1);
        reset = 1'b0;
        bus.req_valid = 2'b01;
        #1;
        check("first_ready", TW'(bus.req_ready), 2'b01);
        step(1);
        bus.req_valid = 2'b00;
        check("single_issue", TW'(bus.kern_issue), 1);
        check("single_busy", TW'(bus.busy), 1);
        check("single_grant", TW'(bus.grant_id), 0);
        check("single_kern_in", bus.kern_in, r0_in);
        check("single_ready_busy", TW'(bus.req_ready), 0);
        step(1);
        check("single_issue_off", TW'(bus.kern_issue), 0);
        check("single_rsp_early", TW'(bus.rsp_valid), 0);
        step(1);
        check("single_rsp_valid", TW'(bus.rsp_valid), 2'b01);
        check("single_rsp_data", bus.rsp_data, r0_out);
        bus.rsp_ready = 2'b01;
        step(1);
        bus.rsp_ready = 2'b00;
        check("single_done_valid", TW'(bus.rsp_valid), 0);
        check("single_idle", TW'(bus.busy), 0);
        check("single_count", TW'(bus.job_count), 1);
        // backpressure with requests arriving while busy
        bus.req_valid = 2'b01;
        step(1);
        bus.req_valid = 2'b11;
        step(2);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", TW'(bus.rsp_valid), 2'b01);
            check("bp_rsp_data", bus.rsp_data, r0_out);
            check("bp_req_ready", TW'(bus.req_ready), 0);
            check("bp_issue", TW'(bus.kern_issue), 0);
            step(1);
        end
        bus.rsp_ready = 2'b10;
        step(1);
        check("bp_wrong_ready", TW'(bus.rsp_valid), 2'b01);
        bus.rsp_ready = 2'b01;
        step(1);
        bus.rsp_ready = 2'b00;
        check("bp_count", TW'(bus.job_count), 2);
        check("stalled_req_served", TW'(bus.req_ready), 2'b10);
        // job of requester 1, non-owner ready ignored
        bus.req_valid = 2'b10;
        step(1);
        bus.req_valid = 2'b00;
        check("own_grant", TW'(bus.grant_id), 1);
        check("own_kern_in", bus.kern_in, r1_in);
        step(2);
        check("own_rsp_valid", TW'(bus.rsp_valid), 2'b10);
        check("own_rsp_data", bus.rsp_data, r1_out);
        bus.rsp_ready = 2'b01;
        step(3);
        check("own_hold", TW'(bus.rsp_valid), 2'b10);
        check("own_count_hold", TW'(bus.job_count), 2);
        bus.rsp_ready = 2'b10;
        step(1);
        check("own_done", TW'(bus.busy), 0);
        check("own_count", TW'(bus.job_count), 3);
        // contention at full rate: grants alternate starting with requester 0
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("cont_ready", TW'(bus.req_ready), (k % 2) ? 2'b10 : 2'b01);
            step(1);
            check("cont_grant", TW'(bus.grant_id), TW'(k % 2));
            check("cont_issue", TW'(bus.kern_issue), 1);
            step(2);
            check("cont_rsp_valid", TW'(bus.rsp_valid), (k % 2) ? 2'b10 : 2'b01);
            check("cont_rsp_data", bus.rsp_data, (k % 2) ? r1_out : r0_out);
            step(1);
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        check("cont_count", TW'(bus.job_count), 7);
        // reset while waiting on the kernel
        bus.req_valid = 2'b01;
        step(1);
        bus.req_valid = 2'b00;
        step(1);
        check("wait_busy", TW'(bus.busy), 1);
        reset = 1'b1;
        bus.req_valid = 2'b11;
        #1;
        check("mid_rst_busy", TW'(bus.busy), 0);
        check("mid_rst_issue", TW'(bus.kern_issue), 0);
        check("mid_rst_rsp_valid", TW'(bus.rsp_valid), 0);
        check("mid_rst_req_ready", TW'(bus.req_ready), 0);
        check("mid_rst_count", TW'(bus.job_count), 0);
        check("mid_rst_kern_in", bus.kern_in, 0);
        check("mid_rst_rsp_data", bus.rsp_data, 0);
        step(1);
        reset = 1'b0;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("post_rst_quiet", TW'({bus.rsp_valid, bus.kern_issue, bus.busy}), 0);
        end
        check("post_rst_count", TW'(bus.job_count), 0);
        bus.req_valid = 2'b11;
        #1;
        check("post_rst_ready", TW'(bus.req_ready), 2'b01);
        step(1);
        bus.req_valid = 2'b00;
        check("post_rst_grant", TW'(bus.grant_id), 0);
        step(3);
        check("post_rst_job", TW'(bus.job_count), 1);
        // count wrap
        force dut.job_cnt = 16'hFFFF;
        step(1);
        release dut.job_cnt;
        check("wrap_preload", TW'(bus.job_count), 16'hFFFF);
        bus.req_valid = 2'b10;
        step(1);
        bus.req_valid = 2'b00;
        step(3);
        check("wrap_count", TW'(bus.job_count), 0);
        check("wrap_idle", TW'(bus.busy), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
